// File: rtl/alu_exec_stage.sv
// alu_exec_stage: EX stage behind the ALU-control decoder. Single-cycle ALU ops
// land in a one-entry output register; variable left shifts (shamt >= 2) walk
// through a 1-bit/cycle serial shifter before writing the same register.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucnt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] acc_shl;
  logic             slot_free;
  logic             accept;
  logic             long_shift;
  logic [WIDTH-1:0] op_res;
  logic             op_ovf;
  logic             op_illegal;

  assign shamt      = b[SHW-1:0];
  assign sum        = a + b;
  assign diff       = a - b;
  assign acc_shl    = {acc_q[WIDTH-2:0], 1'b0};
  // The output slot can take a new entry if it is empty or being drained now.
  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = (state_q == IDLE) && slot_free && !flush;
  assign accept     = in_valid && in_ready;
  // Shifts of 0 or 1 finish in one cycle; anything longer uses the serial shifter.
  assign long_shift = (alucnt == OP_SLL) && (shamt > SHW'(1));

  // Single-cycle ALU result and flags for the op currently on the inputs.
  always_comb begin
    op_res     = '0;
    op_ovf     = 1'b0;
    op_illegal = 1'b0;
    case (alucnt)
      OP_ADD: begin
        op_res = sum;
        op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // Only meaningful for shamt 0/1; longer shifts take the serial path.
      OP_SLL:  op_res = (shamt == '0) ? a : {a[WIDTH-2:0], 1'b0};
      OP_XOR:  op_res = a ^ b;
      OP_NOR:  op_res = ~(a | b);
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: op_illegal = 1'b1;
    endcase
  end

  // Next-state for the FSM, serial shifter and output register; flush wins.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    if (flush) begin
      // Drop the in-flight shift and the output entry; keep the data fields.
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (long_shift) begin
              acc_d   = {a[WIDTH-2:0], 1'b0};
              cnt_d   = shamt - SHW'(1);
              state_d = SHIFT;
            end else begin
              out_valid_d = 1'b1;
              result_d    = op_res;
              zero_d      = (op_res == '0);
              ovf_d       = op_ovf;
              illegal_d   = op_illegal;
            end
          end
        end
        SHIFT: begin
          if (cnt_q > SHW'(1)) begin
            acc_d = acc_shl;
            cnt_d = cnt_q - SHW'(1);
          end else if (slot_free) begin
            // Final bit shifts straight into the output register.
            out_valid_d = 1'b1;
            result_d    = acc_shl;
            zero_d      = (acc_shl == '0);
            ovf_d       = 1'b0;
            illegal_d   = 1'b0;
            cnt_d       = '0;
            state_d     = IDLE;
          end
          // else: output slot still occupied, hold acc/cnt until it frees up.
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, shifter and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the ALU-control decoder: consumes the 4-bit ALU control code plus two 32-bit operands and produces a registered result for the EX/MEM boundary.
- Single-cycle ops complete in 1 cycle. Variable left shift runs on a serial 1-bit/cycle shifter.
- valid/ready handshakes on input and output, one-entry output register, synchronous flush for branch redirect.

Parameters:
- WIDTH, 32, operand/result width
- SHW, 5, shift-amount width (log2 WIDTH)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort: drops in-flight op and output entry
- in_valid  in  1  operands/code valid
- in_ready  out  1  stage can accept
- alucnt  in  4  ALU control code from the decoder
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt/imm); b[SHW-1:0] is the shift amount for sll
- out_valid  out  1  result register holds a valid entry
- out_ready  in  1  downstream accepts
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- ovf  out  1  registered signed overflow (add/sub only, else 0)
- illegal  out  1  registered: alucnt not in the decoded set

Behaviour:
- Code map:
  - 0000 add
  - 0001 sub
  - 0010 sll (a << b[4:0])
  - 0011 xor
  - 0100 nor
  - 0101 and
  - 0110 or
  - 0111 slt (signed; result 1 or 0)
  - 1xxx illegal: result 0, illegal=1, zero=1
- Arithmetic is modulo 2^WIDTH.
  - ovf for add = (a[msb]==b[msb]) && (sum[msb]!=a[msb]).
  - ovf for sub = (a[msb]!=b[msb]) && (diff[msb]!=a[msb]).
- Reset (async, rst_n=0): state IDLE, out_valid=0, result=0, zero=0, ovf=0, illegal=0, shift counter=0, accumulator=0.
- FSM states: IDLE, SHIFT.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready.
- IDLE, accept of a non-sll op, or sll with shamt 0 or 1:
  - Output register written at the same edge; out_valid=1 next cycle. Latency 1.
- IDLE, accept of sll with shamt >= 2:
  - Load acc = a<<1 and cnt = shamt-1; go to SHIFT.
- SHIFT, each edge:
  - If cnt > 1: acc <<= 1, cnt -= 1.
  - If cnt == 1 and output slot free (!out_valid || out_ready): write acc<<1 to the output register, go to IDLE.
  - If cnt == 1 and slot busy: hold acc/cnt unchanged (stall).
  - Total latency = shamt cycles when not back-pressured.
- Output slot:
  - Entry drops when out_valid && out_ready && no same-edge write.
  - Same-edge drain and write is allowed (back-to-back throughput of 1/cycle for single-cycle ops).
  - result/zero/ovf/illegal hold stable while out_valid && !out_ready.
- flush=1 at an edge:
  - out_valid->0 and state->IDLE.
  - Any SHIFT op is discarded; no accept that cycle.
  - result/zero/ovf/illegal hold their last values.
  - flush has priority over every other event.
- Reset mid-SHIFT: immediate return to IDLE, all outputs to reset values, no stale write after release.
- in_valid while in SHIFT: in_ready=0; upstream holds inputs.
- Output fields change only when out_valid is written.

Test Plan:
- add a=0x7FFFFFFF, b=1, out_ready=1 -> one cycle later out_valid=1, result=0x80000000, ovf=1, zero=0; sub a=5, b=5 -> result=0, zero=1, ovf=0.
- Back-to-back stream of and/or/xor/nor/slt (a=0xF0F0F0F0, b=0x0FF00FF0; slt a=-1, b=1) with out_ready=1 -> one result per cycle, in_ready never drops:
  - and 0x00F000F0, or 0xFFF0FFF0, xor 0xFF00FF00, nor 0x000F000F, slt 1.
- sll a=1, b=31 -> in_ready=0 for the SHIFT period, out_valid rises 31 cycles after accept, result=0x80000000. sll shamt 0 and 1 each -> 1-cycle latency, results 1 and 2.
- sll a=3, b=4 with out_ready=0 and the output slot already full -> stalls at cnt==1; raising out_ready drains the old entry and writes 0x30 on the same edge.
- flush asserted mid-SHIFT and while out_valid=1 -> next cycle out_valid=0, state IDLE, in_ready=1, no later spurious out_valid.
- alucnt=1010 -> result=0, illegal=1, zero=1. rst_n pulsed low mid-SHIFT -> all outputs 0 immediately, next accepted op behaves normally.
